// File: rtl/adc_lane_serializer_if.sv
// Sample-input stream of adc_lane_serializer: parallel sample with valid/ready handshake.
interface adc_lane_serializer_if #(
  parameter int SAMPLE_W = 16
);
  logic [SAMPLE_W-1:0] s_data;
  logic                s_valid;
  logic                s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/adc_lane_serializer.sv
// Two-lane LVDS ADC transmit model: input FIFO, SYNC/RUN framing, frame slip, underflow count.
// Optional internal ramp source (pattern_sel input) is built when ADC_TX_RAMP_EN is defined.
module adc_lane_serializer #(
  parameter int         SAMPLE_W    = 16,
  parameter int         FIFO_DEPTH  = 8,
  parameter int         SYNC_FRAMES = 16,
  parameter logic [7:0] FCO_PATTERN = 8'hF0
) (
  input  logic                 CLK,
  input  logic                 cpu_resetn,
  input  logic                 tx_en,
  adc_lane_serializer_if.slave samples,
`ifdef ADC_TX_RAMP_EN
  input  logic                 pattern_sel,
`endif
  input  logic [2:0]           slip,
  output logic                 fco,
  output logic                 d0,
  output logic                 d1,
  output logic                 frame_start,
  output logic                 busy,
  output logic [15:0]          underflow_cnt
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PAD = 16 - SAMPLE_W;
  localparam int FW  = $clog2(SYNC_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;
  state_t state_reg, state_next;

  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]         count_reg;
  logic [2:0]          bit_cnt_reg, pad_cnt_reg, slip_reg;
  logic [FW-1:0]       frame_cnt_reg;
  logic [15:0]         word_reg, underflow_reg;
  logic                fco_reg, d0_reg, d1_reg, frame_start_reg;

  logic        full, empty, push, pop, starve, boundary, padding, load, use_ramp;
  logic [15:0] fifo_word, word_src;
  logic [7:0]  odd_bits, even_bits;
  logic        fco_next, d0_next, d1_next, frame_start_next;

  assign full      = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign empty     = (count_reg == '0);
  assign samples.s_ready = cpu_resetn && !full;
  assign push      = samples.s_valid && samples.s_ready;
  assign boundary  = (bit_cnt_reg == 3'd7);
  assign padding   = (pad_cnt_reg != 3'd0);
  assign fifo_word = 16'(mem[rd_ptr_reg]) << PAD;

`ifdef ADC_TX_RAMP_EN
  logic [SAMPLE_W-1:0] ramp_reg, ramp_val;
  // The ramp restarts from zero on the frame that enters RUN.
  assign ramp_val = (state_reg == SYNC) ? '0 : ramp_reg;
  assign use_ramp = pattern_sel;
  assign word_src = use_ramp ? (16'(ramp_val) << PAD) : fifo_word;
`else
  assign use_ramp = 1'b0;
  assign word_src = fifo_word;
`endif

  assign pop    = load && !use_ramp && !empty;
  assign starve = load && !use_ramp && empty;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lanes
      assign odd_bits[gi]  = word_reg[2*gi+1];
      assign even_bits[gi] = word_reg[2*gi];
    end
  endgenerate

  always_comb begin
    state_next       = state_reg;
    load             = 1'b0;
    fco_next         = 1'b0;
    d0_next          = 1'b0;
    d1_next          = 1'b0;
    frame_start_next = 1'b0;
    case (state_reg)
      IDLE: if (tx_en) state_next = SYNC;
      SYNC: if (boundary) begin
        if (!tx_en) begin
          state_next = IDLE;
        end else if (frame_cnt_reg == FW'(SYNC_FRAMES - 1)) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: if (boundary) begin
        if (!tx_en) state_next = IDLE;
        else        load       = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    // Bit k of the frame is selected by index 7-k, i.e. the inverted counter.
    if (state_reg != IDLE && !padding) begin
      fco_next         = FCO_PATTERN[~bit_cnt_reg];
      frame_start_next = (bit_cnt_reg == 3'd0);
      if (state_reg == RUN) begin
        d1_next = odd_bits[~bit_cnt_reg];
        d0_next = even_bits[~bit_cnt_reg];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_reg] <= samples.s_data;
  end

  always_ff @(posedge CLK) begin
    if (!cpu_resetn) begin
      state_reg       <= IDLE;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      bit_cnt_reg     <= '0;
      pad_cnt_reg     <= '0;
      slip_reg        <= '0;
      frame_cnt_reg   <= '0;
      word_reg        <= '0;
      underflow_reg   <= '0;
      fco_reg         <= 1'b0;
      d0_reg          <= 1'b0;
      d1_reg          <= 1'b0;
      frame_start_reg <= 1'b0;
`ifdef ADC_TX_RAMP_EN
      ramp_reg        <= '0;
`endif
    end else begin
      state_reg <= state_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase

      if (state_reg == IDLE || padding) bit_cnt_reg <= 3'd0;
      else                              bit_cnt_reg <= bit_cnt_reg + 1'b1;

      // A changed slip value inserts that many blank bit-times once, before the next frame.
      if (padding) begin
        pad_cnt_reg <= pad_cnt_reg - 1'b1;
      end else if (boundary) begin
        slip_reg <= slip;
        if (slip != slip_reg && state_next != IDLE) pad_cnt_reg <= slip;
      end

      if (state_reg == IDLE)                 frame_cnt_reg <= '0;
      else if (state_reg == SYNC && boundary) frame_cnt_reg <= frame_cnt_reg + 1'b1;

      if (load && (use_ramp || !empty)) word_reg <= word_src;
      if (starve && underflow_reg != 16'hFFFF) underflow_reg <= underflow_reg + 1'b1;
`ifdef ADC_TX_RAMP_EN
      if (load) ramp_reg <= use_ramp ? ramp_val + 1'b1 : ramp_val;
`endif

      fco_reg         <= fco_next;
      d0_reg          <= d0_next;
      d1_reg          <= d1_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign fco           = fco_reg;
  assign d0            = d0_reg;
  assign d1            = d1_reg;
  assign frame_start   = frame_start_reg;
  assign busy          = (state_reg != IDLE);
  assign underflow_cnt = underflow_reg;
endmodule
